cfg_scan_arbiter: RTL and testbench
===================================

# cfg_scan_arbiter

Arbiter and sequencer for the generator's single-port configuration RAM. It shares the RAM between the FSMC host port, which has priority, and a background scanner. The scanner walks the 16 channel-parameter locations (wave/amp/freq/duty × 4 channels) and emits a ready/valid update only for bytes that differ from its shadow copy. It sits between the FSMC bus decode and the four waveform channels.

## Interface
Parameters:
- NUM_REGS, 16: scanned locations 0..NUM_REGS-1.
- SCAN_DIV, 1250: CLK cycles between scan-step requests.

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  reset, asynchronous, active-low.
- host_req  in  1  host access request, level, held until host_ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req.
- host_addr  in  8  host RAM address, full 0..255 range allowed.
- host_wdata  in  16  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  16  read data, valid while host_ack=1, held afterwards.
- ram_addr  out  8  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_rden  out  1  RAM read enable.
- ram_q  in  16  RAM read data, valid 1 cycle after ram_rden.
- upd_valid  out  1  parameter update pending.
- upd_ready  in  1  channel side accepts the update.
- upd_addr  out  4  parameter index: ch = addr[3:2], field = addr[1:0].
- upd_data  out  8  new parameter byte.

## Operation
- FSM states: IDLE, HOST_WR, HOST_RD, HOST_RD_WAIT, SCAN_RD, SCAN_CMP. Only the FSM drives RAM ports. In IDLE all RAM enables are 0.
- Divider: a counter runs 0..SCAN_DIV-1. On wrap it sets scan_pend. scan_pend is cleared when SCAN_RD is entered.
- IDLE priority:
  - host_req=1: go to HOST_WR if host_we=1, else HOST_RD.
  - else, if scan_pend=1 and upd_valid=0: go to SCAN_RD.
  - else stay in IDLE.
- HOST_WR: drive ram_addr=host_addr, ram_wdata=host_wdata, ram_wren=1, host_ack=1; then go to IDLE.
- HOST_RD: drive ram_addr=host_addr, ram_rden=1; then go to HOST_RD_WAIT.
- HOST_RD_WAIT: host_rdata<=ram_q, host_ack=1; then go to IDLE.
- SCAN_RD: drive ram_addr=scan_idx, ram_rden=1; then go to SCAN_CMP.
- SCAN_CMP: compare ram_q[7:0] against shadow[scan_idx].
  - If they differ: shadow[scan_idx]<=ram_q[7:0], upd_addr<=scan_idx, upd_data<=ram_q[7:0], upd_valid<=1.
  - In all cases: scan_idx increments, wrapping NUM_REGS-1 → 0. Then go to IDLE.
  - ram_q[15:8] is ignored.
- Update handshake:
  - upd_valid clears on the cycle where upd_valid & upd_ready.
  - upd_addr and upd_data stay stable while valid.
  - Host traffic is never blocked by a stalled upd_ready. Only scanning is blocked.
- Host must deassert host_req (or present a new request) in the cycle after host_ack. A request still high in IDLE is served again.

## Timing
- Reset: every output is 0, state=IDLE, scan_idx=0, shadow all 0, divider=0, scan_pend=0.
- Host write: request seen in IDLE at cycle N → wren and ack at N+1.
- Host read: ack and rdata at N+2.
- Scan step: scan_pend observed in IDLE at N → SCAN_RD at N+1 → SCAN_CMP at N+2 → upd_valid=1 from N+3.
- host_req and scan_pend both set in IDLE: host wins; scan_pend stays set and is served on the next IDLE cycle without a host request.
- Divider wraps while scan_pend is already set: no effect (no queue of steps).
- Host write to the location being scanned between SCAN_RD and SCAN_CMP: scan uses the old value; the new value is picked up on the next lap.
- Reset asserted mid-access: immediate return to reset values. Any in-flight host_ack or upd_valid is dropped.
- A full lap is NUM_REGS × SCAN_DIV cycles when no update is stalled.

## Structure
- Package gen_cfg_pkg holds:
  - the NUM_REGS default;
  - field offsets FLD_WAVE=0, FLD_AMP=1, FLD_FREQ=2, FLD_DUTY=3;
  - the FSM state encoding.
- Sub-module scan_tick_div (SCAN_DIV counter producing a one-cycle tick). The shadow array and FSM stay in the top.

## Test plan
- Reset, RAM all 0, upd_ready=1, run 2 laps → no upd_valid. Scan addresses cycle 0..15 then wrap to 0.
- Host write addr 0x05 = 0x0037 → ack at N+1. Within one lap: one update with upd_addr=5, upd_data=0x37. Next lap: no further update.
- Host read addr 0x05 after that write → ack at N+2 with host_rdata=0x0037. Write 0xA5C3 to addr 0x80 → no update on any lap.
- Force host_req high on the same cycle as scan_pend → host served first; SCAN_RD follows without losing the step.
- Write addr 2 = 0x10 and addr 3 = 0x20, hold upd_ready=0 → upd_valid stays high with (2, 0x10) and scanning stalls. Host reads still ack at N+2. Release upd_ready → (3, 0x20) follows.
- Assert RST_n low during SCAN_CMP with an update pending → all outputs 0. After release, the scan restarts at index 0 and the shadow is 0, so nonzero RAM bytes are re-emitted.

Source files
------------

// File: rtl/gen_cfg_pkg.sv
// Shared definitions for the generator configuration RAM arbiter.
// Holds the default scanned-location count, the per-channel field offsets
// (parameter index = {channel[1:0], field[1:0]}) and the arbiter FSM encoding.
package gen_cfg_pkg;

  localparam int NUM_REGS_DEF = 16;

  localparam logic [1:0] FLD_WAVE = 2'd0;
  localparam logic [1:0] FLD_AMP  = 2'd1;
  localparam logic [1:0] FLD_FREQ = 2'd2;
  localparam logic [1:0] FLD_DUTY = 2'd3;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    HOST_WR      = 3'd1,
    HOST_RD      = 3'd2,
    HOST_RD_WAIT = 3'd3,
    SCAN_RD      = 3'd4,
    SCAN_CMP     = 3'd5
  } state_t;

endpackage

// File: rtl/scan_tick_div.sv
// Free-running divider that emits a one-cycle tick every DIV clock cycles.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   tick_o  registered one-cycle pulse, once per DIV cycles
module scan_tick_div #(
  parameter int DIV = 1250
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..DIV-1 and flag the wrap.
  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/cfg_scan_arbiter.sv
// Arbiter/sequencer for the single-port configuration RAM. The host port has
// priority; a background scanner walks locations 0..NUM_REGS-1 and raises a
// ready/valid update whenever a low byte differs from its shadow copy.
// Ports:
//   CLK, RST_n                  clock, asynchronous active-low reset
//   host_req/we/addr/wdata      host access request (level, held until ack)
//   host_ack, host_rdata        completion pulse and read data
//   ram_addr/wdata/wren/rden    RAM control; ram_q arrives 1 cycle after rden
//   upd_valid/ready/addr/data   parameter update stream to the channels
module cfg_scan_arbiter
  import gen_cfg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SCAN_DIV = 1250
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_wren,
  output logic        ram_rden,
  input  logic [15:0] ram_q,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [3:0]  upd_addr,
  output logic [7:0]  upd_data
);

  localparam logic [3:0] IDX_LAST = 4'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [3:0]  scan_idx_q, scan_idx_d;
  logic        scan_pend_q, scan_pend_d;
  logic        tick_s;
  logic        shadow_wr_s;
  logic [7:0]  shadow_q [NUM_REGS];

  logic        upd_valid_q, upd_valid_d;
  logic [3:0]  upd_addr_q, upd_addr_d;
  logic [7:0]  upd_data_q, upd_data_d;
  logic [15:0] host_rdata_q, host_rdata_d;
  logic        host_ack_q, host_ack_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;
  logic        ram_wren_q, ram_wren_d;
  logic        ram_rden_q, ram_rden_d;

  scan_tick_div #(.DIV(SCAN_DIV)) u_tick_div (
    .clk_i  (CLK),
    .rst_ni (RST_n),
    .tick_o (tick_s)
  );

  // Next state, scan bookkeeping, and the RAM/host outputs for the next state.
  // Outputs are decoded from state_d so they come straight out of flops.
  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    scan_pend_d  = scan_pend_q | tick_s;
    upd_valid_d  = upd_valid_q & ~upd_ready;
    upd_addr_d   = upd_addr_q;
    upd_data_d   = upd_data_q;
    host_rdata_d = host_rdata_q;
    shadow_wr_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (host_req) begin
          state_d = host_we ? HOST_WR : HOST_RD;
        end else if (scan_pend_q && !upd_valid_q) begin
          // A tick landing on this same cycle is absorbed: steps do not queue.
          state_d     = SCAN_RD;
          scan_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      HOST_WR:      state_d = IDLE;
      HOST_RD:      state_d = HOST_RD_WAIT;
      HOST_RD_WAIT: begin
        host_rdata_d = ram_q;
        state_d      = IDLE;
      end
      SCAN_RD:      state_d = SCAN_CMP;
      SCAN_CMP: begin
        // upd_valid is guaranteed low here: scanning only starts when it is.
        if (ram_q[7:0] != shadow_q[scan_idx_q]) begin
          shadow_wr_s = 1'b1;
          upd_valid_d = 1'b1;
          upd_addr_d  = scan_idx_q;
          upd_data_d  = ram_q[7:0];
        end else begin
          shadow_wr_s = 1'b0;
        end
        scan_idx_d = (scan_idx_q == IDX_LAST) ? 4'd0 : scan_idx_q + 4'd1;
        state_d    = IDLE;
      end
      default:      state_d = IDLE;
    endcase

    ram_addr_d  = 8'd0;
    ram_wdata_d = 16'd0;
    ram_wren_d  = 1'b0;
    ram_rden_d  = 1'b0;
    host_ack_d  = 1'b0;
    case (state_d)
      HOST_WR: begin
        ram_addr_d  = host_addr;
        ram_wdata_d = host_wdata;
        ram_wren_d  = 1'b1;
        host_ack_d  = 1'b1;
      end
      HOST_RD: begin
        ram_addr_d = host_addr;
        ram_rden_d = 1'b1;
      end
      HOST_RD_WAIT: host_ack_d = 1'b1;
      SCAN_RD: begin
        ram_addr_d = {4'b0000, scan_idx_q};
        ram_rden_d = 1'b1;
      end
      default: ram_wren_d = 1'b0;
    endcase
  end

  // Control, handshake and output registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= IDLE;
      scan_idx_q   <= 4'd0;
      scan_pend_q  <= 1'b0;
      upd_valid_q  <= 1'b0;
      upd_addr_q   <= 4'd0;
      upd_data_q   <= 8'd0;
      host_rdata_q <= 16'd0;
      host_ack_q   <= 1'b0;
      ram_addr_q   <= 8'd0;
      ram_wdata_q  <= 16'd0;
      ram_wren_q   <= 1'b0;
      ram_rden_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      scan_pend_q  <= scan_pend_d;
      upd_valid_q  <= upd_valid_d;
      upd_addr_q   <= upd_addr_d;
      upd_data_q   <= upd_data_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_wren_q   <= ram_wren_d;
      ram_rden_q   <= ram_rden_d;
    end
  end

  // Shadow copy of the last byte emitted per location.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= 8'd0;
      end
    end else if (shadow_wr_s) begin
      shadow_q[scan_idx_q] <= ram_q[7:0];
    end
  end

  assign host_ack   = host_ack_q;
  // RAM data only arrives in the ack cycle, so it is bypassed there and
  // held from the register afterwards.
  assign host_rdata = (state_q == HOST_RD_WAIT) ? ram_q : host_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_wren   = ram_wren_q;
  assign ram_rden   = ram_rden_q;
  assign upd_valid  = upd_valid_q;
  assign upd_addr   = upd_addr_q;
  assign upd_data   = upd_data_q;

endmodule

// File: tb/tb_cfg_scan_arbiter.sv
// Self-checking bench for cfg_scan_arbiter: directed steps plus randomized
// host traffic, checked against a shadow/memory reference model.
module tb_cfg_scan_arbiter;
  import gen_cfg_pkg::*;

  localparam int NREG = 16;
  localparam int DIV  = 20;
  localparam int LAP  = NREG * DIV;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [7:0]  host_addr = 8'd0;
  logic [15:0] host_wdata = 16'd0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_wren, ram_rden;
  logic [15:0] ram_q = 16'd0;
  logic        upd_valid;
  logic        upd_ready = 1'b1;
  logic [3:0]  upd_addr;
  logic [7:0]  upd_data;

  always #5 CLK = ~CLK;

  cfg_scan_arbiter #(.NUM_REGS(NREG), .SCAN_DIV(DIV)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .ram_rden(ram_rden), .ram_q(ram_q),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_addr(upd_addr), .upd_data(upd_data)
  );

  // Synchronous single-port RAM, data one cycle after rden.
  logic [15:0] ram_arr [256] = '{default: 16'h0};
  always @(posedge CLK) begin
    if (ram_wren) ram_arr[ram_addr] <= ram_wdata;
    if (ram_rden) ram_q <= ram_arr[ram_addr];
  end

  typedef struct { logic [3:0] a; logic [7:0] d; } upd_t;
  upd_t        upd_log [$];
  logic [7:0]  scan_log [$];
  int          scan_cyc [$];
  int          cyc = 0;
  logic        prev_rden = 1'b0;
  logic [7:0]  prev_addr = 8'd0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Observer: a RAM read not followed by host_ack is a scan read.
  always @(negedge CLK) begin
    if (RST_n) begin
      if (prev_rden && !host_ack) begin
        scan_log.push_back(prev_addr);
        scan_cyc.push_back(cyc - 1);
      end
      if (upd_valid && upd_ready) upd_log.push_back('{a: upd_addr, d: upd_data});
      prev_rden <= ram_rden;
      prev_addr <= ram_addr;
    end else begin
      prev_rden <= 1'b0;
    end
  end

  // Reference model state.
  logic [15:0] ref_mem  [256];
  logic [7:0]  shadow_m [NREG];
  int  n_pass = 0, n_total = 0;
  bit  rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (rand_ready) upd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d, output int lat);
    host_addr = a; host_wdata = d; host_we = 1'b1; host_req = 1'b1; lat = 0;
    do begin step(); lat++; end while (!host_ack && lat < 100);
    host_req = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [15:0] d, output int lat);
    host_addr = a; host_we = 1'b0; host_req = 1'b1; lat = 0;
    do begin step(); lat++; end while (!host_ack && lat < 100);
    d = host_rdata;
    host_req = 1'b0;
  endtask

  // Return just after a scan step has completed, leaving the FSM idle.
  task automatic sync_idle(input string tag);
    int n0 = scan_log.size();
    int b = 0;
    while (scan_log.size() == n0 && b < 4 * DIV) begin step(); b++; end
    check(tag, 32'(scan_log.size() > n0), 32'd1);
    step();
  endtask

  task automatic check_outputs_zero(input string p);
    check({p, "_ack"},   host_ack,   0);
    check({p, "_rdata"}, host_rdata, 0);
    check({p, "_raddr"}, ram_addr,   0);
    check({p, "_wdata"}, ram_wdata,  0);
    check({p, "_wren"},  ram_wren,   0);
    check({p, "_rden"},  ram_rden,   0);
    check({p, "_valid"}, upd_valid,  0);
    check({p, "_uaddr"}, upd_addr,   0);
    check({p, "_udata"}, upd_data,   0);
  endtask

  // Run, then compare emitted updates (as a set) with the bytes that differ
  // from the model shadow; afterwards the shadow is brought up to date.
  task automatic settle(input string tag, input int cycles);
    int  exp_n = 0;
    int  bad = 0;
    bit  seen [NREG];
    repeat (cycles) step();
    for (int i = 0; i < NREG; i++) begin
      seen[i] = 1'b0;
      if (ref_mem[i][7:0] != shadow_m[i]) exp_n++;
    end
    foreach (upd_log[j]) begin
      if (seen[upd_log[j].a] || shadow_m[upd_log[j].a] == ref_mem[upd_log[j].a][7:0]
          || upd_log[j].d != ref_mem[upd_log[j].a][7:0]) bad++;
      seen[upd_log[j].a] = 1'b1;
    end
    check({tag, "_count"}, upd_log.size(), exp_n);
    check({tag, "_content"}, bad, 0);
    for (int i = 0; i < NREG; i++) shadow_m[i] = ref_mem[i][7:0];
    upd_log.delete();
  endtask

  initial begin
    int          lat, bad, n0, t, k, b, vcyc;
    logic [15:0] rd;
    int          perm [NREG];
    upd_t        exp_q [$];

    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    for (int i = 0; i < NREG; i++) shadow_m[i] = 8'h0;

    // Reset state.
    repeat (3) step();
    check_outputs_zero("reset");
    RST_n = 1'b1;

    // Two idle laps over zeroed RAM: no updates, addresses cycle 0..15.
    repeat (2 * LAP + DIV) step();
    check("idle_no_upd", upd_log.size(), 0);
    check("idle_scan_cnt_ok", 32'(scan_log.size() >= 32 && scan_log.size() <= 34), 1);
    bad = 0;
    for (int i = 0; i < 32 && i < scan_log.size(); i++)
      if (scan_log[i] != 8'(i % NREG)) bad++;
    check("idle_scan_seq", bad, 0);

    // Host write to channel 1 amplitude (index 5).
    sync_idle("sync_wr5");
    host_write({4'd0, 2'd1, FLD_AMP}, 16'h0037, lat);
    check("wr5_latency", lat, 1);
    b = 0;
    while (!upd_valid && b < LAP + 2 * DIV) begin step(); b++; end
    vcyc = cyc;
    check("wr5_valid_seen", upd_valid, 1);
    check("wr5_ram", ram_arr[5], 16'h0037);
    check("wr5_upd_addr", upd_addr, 5);
    check("wr5_upd_data", upd_data, 8'h37);
    check("wr5_scan_addr", (scan_log.size() > 0) ? scan_log[$] : 8'hFF, 8'd5);
    check("wr5_valid_lat", (scan_cyc.size() > 0) ? vcyc - scan_cyc[$] : -1, 2);
    settle("lap1", LAP + DIV);
    settle("lap2", LAP + DIV);

    // Host reads and an out-of-range write.
    sync_idle("sync_rd5");
    host_read(8'h05, rd, lat);
    check("rd5_latency", lat, 2);
    check("rd5_data", rd, 16'h0037);
    sync_idle("sync_wr80");
    host_write(8'h80, 16'hA5C3, lat);
    check("wr80_latency", lat, 1);
    sync_idle("sync_rd80");
    host_read(8'h80, rd, lat);
    check("rd80_latency", lat, 2);
    check("rd80_data", rd, 16'hA5C3);
    settle("hi_addr", LAP + DIV);

    // Back-to-back host writes starve the scanner; the pending step survives.
    sync_idle("sync_prio");
    n0 = scan_log.size();
    t = 0; k = 0;
    while (t < 3 * DIV) begin
      host_write(8'(8'h90 + k), 16'(k), lat);
      t += lat; k++;
    end
    check("prio_b2b_latency", lat, 2);
    check("prio_starved", scan_log.size(), n0);
    step();
    check("prio_idle_rden", ram_rden, 0);
    step();
    check("prio_scan_rden", ram_rden, 1);
    check("prio_scan_addr", ram_addr, 8'(n0 % NREG));
    settle("prio", LAP + DIV);

    // Stalled update blocks scanning but not the host.
    n0 = scan_log.size(); b = 0;
    while (!(scan_log.size() > n0 && scan_log[$] == 8'd3) && b < 2 * LAP) begin step(); b++; end
    check("stall_sync", scan_log[$], 8'd3);
    upd_ready = 1'b0;
    host_write({4'd0, 2'd0, FLD_FREQ}, 16'h0010, lat);
    host_write({4'd0, 2'd0, FLD_DUTY}, 16'h0020, lat);
    b = 0;
    while (!upd_valid && b < LAP + 2 * DIV) begin step(); b++; end
    n0 = scan_log.size();
    repeat (3 * DIV) step();
    check("stall_valid", upd_valid, 1);
    check("stall_addr", upd_addr, 2);
    check("stall_data", upd_data, 8'h10);
    check("stall_no_scan", scan_log.size(), n0);
    host_read(8'h05, rd, lat);
    check("stall_rd_latency", lat, 2);
    check("stall_rd_data", rd, 16'h0037);
    upd_ready = 1'b1;
    repeat (4 * DIV) step();
    check("stall_rel_count", upd_log.size(), 2);
    check("stall_rel_first", (upd_log.size() > 0) ? {upd_log[0].a, upd_log[0].d} : 12'hFFF, 12'h210);
    check("stall_rel_second", (upd_log.size() > 1) ? {upd_log[1].a, upd_log[1].d} : 12'hFFF, 12'h320);
    upd_log.delete();
    shadow_m[2] = 8'h10; shadow_m[3] = 8'h20;

    // Reset during SCAN_CMP of a changed byte.
    sync_idle("sync_rst");
    host_write({4'd0, 2'd2, FLD_WAVE}, 16'h00AB, lat);
    b = 0;
    while (!(ram_rden && ram_addr == 8'd8 && !host_req) && b < 2 * LAP) begin step(); b++; end
    check("rst_scan8_seen", ram_addr, 8'd8);
    step();
    RST_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    scan_log.delete(); scan_cyc.delete(); upd_log.delete();
    for (int i = 0; i < NREG; i++) shadow_m[i] = 8'h0;
    repeat (2) step();
    RST_n = 1'b1;
    repeat (LAP + 2 * DIV) step();
    check("rst_first_idx", (scan_log.size() > 0) ? scan_log[0] : 8'hFF, 8'h00);
    for (int i = 0; i < NREG; i++)
      if (ref_mem[i][7:0] != 8'h0) exp_q.push_back('{a: 4'(i), d: ref_mem[i][7:0]});
    bad = 0;
    foreach (exp_q[j])
      if (j >= upd_log.size() || upd_log[j].a != exp_q[j].a || upd_log[j].d != exp_q[j].d) bad++;
    check("rst_reemit_count", upd_log.size(), exp_q.size());
    check("rst_reemit_order", bad, 0);
    upd_log.delete();
    for (int i = 0; i < NREG; i++) shadow_m[i] = ref_mem[i][7:0];

    // Randomized rounds with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NREG; i++) perm[i] = i;
      for (int i = NREG - 1; i > 0; i--) begin
        int j = $urandom_range(0, i);
        int tmp = perm[i];
        perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < 5; i++) host_write(8'(perm[i]), 16'($urandom), lat);
      for (int i = 0; i < 3; i++) host_write(8'($urandom_range(16, 255)), 16'($urandom), lat);
      for (int i = 0; i < 4; i++) begin
        logic [7:0] ra;
        ra = 8'($urandom_range(0, 255));
        host_read(ra, rd, lat);
        check("rand_rd_data", rd, ref_mem[ra]);
      end
      settle("rand", 3 * LAP);
    end
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
